dac_play_seq: RTL and testbench

Playback sequencer for the DAC waveform buffer. Owns the single port of the waveform BRAM. While idle it accepts PS-side sample writes; once started it sweeps the buffer from address 0 to a programmed last address, paced by the DAC sample strobe. Sweep mode is single-shot, continuous loop or N-repetition burst, and the block reports progress and completion back to the PS.

---
 rtl/dac_pkg.sv | 23 ++
 rtl/dac_play_seq_if.sv | 14 +
 rtl/play_addr_gen.sv | 47 ++++
 rtl/dac_play_seq.sv | 114 +++++++++++
 tb/tb_dac_play_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared encodings and widths for the DAC playback sequencer.
package dac_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int REP_W      = 16;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_LOOP   = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;

  typedef enum logic [1:0] {IDLE, ARM, PLAY, DRAIN} state_t;

  // A zero repetition count still plays one pass.
  function automatic logic [REP_W-1:0] eff_reps(input logic [REP_W-1:0] r);
    return (r == '0) ? REP_W'(1) : r;
  endfunction

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/dac_play_seq_if.sv
// Single-port waveform BRAM bus driven by the playback sequencer.
// No handshake: a transfer happens in every cycle bram_en is high; bram_we selects write vs read.
interface dac_play_seq_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;

  modport master (output bram_en, bram_we, bram_addr, bram_wdata);
  modport slave  (input  bram_en, bram_we, bram_addr, bram_wdata);
endinterface

// File: rtl/play_addr_gen.sv
// Playback address counter with wrap at the latched last address and a pass counter.
module play_addr_gen
  import dac_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic [REP_W-1:0]  rep_count,
  output logic [ADDR_W-1:0] addr,
  output logic              pass_end,
  output logic              last_pass
);

  logic [ADDR_W-1:0] max_l;
  logic [REP_W-1:0]  reps_l;
  logic [REP_W-1:0]  pass_cnt;

  // clr doubles as the configuration latch so a sweep is immune to input changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      max_l    <= '0;
      reps_l   <= '0;
      pass_cnt <= '0;
    end else if (clr) begin
      addr     <= '0;
      pass_cnt <= '0;
      max_l    <= max_addr;
      reps_l   <= eff_reps(rep_count);
    end else if (adv) begin
      if (pass_end) begin
        addr     <= '0;
        pass_cnt <= pass_cnt + REP_W'(1);
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  assign pass_end  = (addr == max_l);
  assign last_pass = (pass_cnt == reps_l - REP_W'(1));

endmodule

// File: rtl/dac_play_seq.sv
// Playback sequencer: PS writes while idle, paced sweeps of the waveform BRAM when started.
module dac_play_seq
  import dac_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_err,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     max_addr,
  input  logic [REP_W-1:0]      rep_count,
  input  logic                  sample_tick,
  dac_play_seq_if.master        bram,
  output logic                  sample_valid,
  output logic                  sample_last,
  output logic                  busy,
  output logic                  done,
  output state_t                state_dbg
);

  state_t            state, state_nx;
  logic [1:0]        mode_l;
  logic              clr, issue, nat_end, wr_ok;
  logic              rd_q, rd_last_q;
  logic [ADDR_W-1:0] gen_addr;
  logic              pass_end, last_pass;

  play_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .adv       (issue),
    .max_addr  (max_addr),
    .rep_count (rep_count),
    .addr      (gen_addr),
    .pass_end  (pass_end),
    .last_pass (last_pass)
  );

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    issue    = 1'b0;
    nat_end  = 1'b0;
    wr_ok    = (state == IDLE) && wr_en;
    case (state)
      IDLE:  if (start && !stop) state_nx = ARM;
      ARM: begin
        clr      = 1'b1;
        state_nx = PLAY;
      end
      PLAY: begin
        // stop suppresses a coincident tick so no read is left in flight.
        if (stop) begin
          state_nx = DRAIN;
        end else if (sample_tick) begin
          issue   = 1'b1;
          nat_end = pass_end && ((mode_l == MODE_SINGLE) ||
                                 ((mode_l == MODE_BURST) && last_pass));
          if (nat_end) state_nx = DRAIN;
        end
      end
      DRAIN: if (!rd_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mode_l          <= MODE_SINGLE;
      bram.bram_en    <= 1'b0;
      bram.bram_we    <= 1'b0;
      bram.bram_addr  <= '0;
      bram.bram_wdata <= '0;
      wr_err          <= 1'b0;
      rd_q            <= 1'b0;
      rd_last_q       <= 1'b0;
      sample_valid    <= 1'b0;
      sample_last     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr) mode_l <= norm_mode(mode);
      bram.bram_en <= wr_ok || issue;
      bram.bram_we <= wr_ok;
      if (wr_ok) begin
        bram.bram_addr  <= wr_addr;
        bram.bram_wdata <= wr_data;
      end else if (issue) begin
        bram.bram_addr <= gen_addr;
      end
      wr_err <= wr_en && (state != IDLE);
      // One-cycle BRAM latency: the read issued last cycle returns data now.
      rd_q         <= issue;
      rd_last_q    <= issue && nat_end;
      sample_valid <= rd_q;
      sample_last  <= rd_q && rd_last_q;
      busy         <= (state_nx != IDLE);
      done         <= (state == DRAIN) && (state_nx == IDLE);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_dac_play_seq.sv
// Directed bench for dac_play_seq with a BRAM model and a read-sequence scoreboard.
module tb_dac_play_seq;
  import dac_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 0, start = 0, stop = 0, sample_tick = 0;
  logic [AW-1:0] wr_addr = '0, max_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    mode = 2'b00;
  logic [15:0]   rep_count = '0;
  logic          wr_err, sample_valid, sample_last, busy, done;
  state_t        state_dbg;

  dac_play_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bram_if ();

  dac_play_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk), .rst_n (rst_n),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_err (wr_err),
    .start (start), .stop (stop), .mode (mode), .max_addr (max_addr),
    .rep_count (rep_count), .sample_tick (sample_tick), .bram (bram_if),
    .sample_valid (sample_valid), .sample_last (sample_last),
    .busy (busy), .done (done), .state_dbg (state_dbg)
  );

  // BRAM model, read latency 1
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata;
  always @(posedge clk)
    if (bram_if.bram_en) begin
      if (bram_if.bram_we) mem[bram_if.bram_addr] <= bram_if.bram_wdata;
      else                 rdata <= mem[bram_if.bram_addr];
    end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] shadow [0:15];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] obs_addr_q[$];
  logic [DW-1:0] obs_data_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_valid_cyc = -10, stop_cyc = -10, done_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected reads from the playback rules: n reads, address i mod (max+1).
  task automatic build_exp(input logic [1:0] m, input int mx, input int reps, input int nloop,
                           output int n);
    int passes;
    passes = (reps == 0) ? 1 : reps;
    if (m == MODE_LOOP)       n = nloop;
    else if (m == MODE_BURST) n = (mx + 1) * passes;
    else                      n = mx + 1;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'(i % (mx + 1));
      exp_addr_q.push_back(a);
      exp_q.push_back({(m != MODE_LOOP) && (i == n - 1), shadow[a[3:0]]});
    end
    obs_addr_q.delete();
    obs_data_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_if.bram_en && !bram_if.bram_we) begin
        obs_addr_q.push_back(bram_if.bram_addr);
        check("read_expected", 32'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) check("read_addr", 32'(bram_if.bram_addr), 32'(exp_addr_q.pop_front()));
      end
      if (sample_valid) begin
        logic [DW:0] e;
        last_valid_cyc = cyc;
        obs_data_q.push_back(rdata);
        check("valid_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sample_data", 32'(rdata), 32'(e[DW-1:0]));
          check("sample_last", 32'(sample_last), 32'(e[DW]));
        end
      end else if (sample_last) begin
        check("last_without_valid", 32'(sample_last), 0);
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", 32'(busy), 0);
        check("done_timing", 32'((last_valid_cyc == cyc - 1) || (stop_cyc == cyc - 2)), 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int a, input int d);
    wr_en = 1; wr_addr = AW'(a); wr_data = DW'(d);
    step();
    wr_en = 0;
    shadow[a[3:0]] = DW'(d);
    @(negedge clk);
    check("wr_en", 32'(bram_if.bram_en), 1);
    check("wr_we", 32'(bram_if.bram_we), 1);
    check("wr_addr", 32'(bram_if.bram_addr), a);
    check("wr_data", 32'(bram_if.bram_wdata), d);
  endtask

  task automatic start_play(input logic [1:0] m, input int mx, input int reps);
    mode = m; max_addr = AW'(mx); rep_count = 16'(reps);
    start = 1;
    step();
    start = 0;
    step();
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1;
      step();
      sample_tick = 0;
      repeat (gap - 1) step();
    end
  endtask

  task automatic wait_idle(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin seen = 1; break; end
    end
    check("idle_reached", 32'(seen), 1);
    step();
  endtask

  task automatic end_of_test(input string name, input int d0, input int exp_done);
    check({name, "_addr_q_empty"}, 32'(exp_addr_q.size()), 0);
    check({name, "_data_q_empty"}, 32'(exp_q.size()), 0);
    check({name, "_done_count"}, 32'(done_cnt - d0), 32'(exp_done));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, d0;
    logic [DW-1:0] lit_data [4];
    logic [AW-1:0] lit_burst [6];
    logic [AW-1:0] lit_loop [7];
    lit_data  = '{16'd10, 16'd20, 16'd30, 16'd40};
    lit_burst = '{12'd0, 12'd1, 12'd0, 12'd1, 12'd0, 12'd1};
    lit_loop  = '{12'd0, 12'd1, 12'd2, 12'd0, 12'd1, 12'd2, 12'd0};
    for (int i = 0; i < 16; i++) shadow[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_bram_en", 32'(bram_if.bram_en), 0);
    check("rst_bram_we", 32'(bram_if.bram_we), 0);
    check("rst_bram_addr", 32'(bram_if.bram_addr), 0);
    check("rst_bram_wdata", 32'(bram_if.bram_wdata), 0);
    check("rst_outputs", 32'({sample_valid, sample_last, busy, done, wr_err}), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1 rst_n = 1;
    step();

    // write then single-shot
    do_write(0, 10); do_write(1, 20); do_write(2, 30); do_write(3, 40);
    step();
    d0 = done_cnt;
    build_exp(MODE_SINGLE, 3, 0, 0, n);
    start_play(MODE_SINGLE, 3, 0);
    check("single_busy", 32'(busy), 1);
    ticks(n, 4);
    wait_idle(20);
    repeat (3) step();
    end_of_test("single", d0, 1);
    check("single_count", 32'(obs_data_q.size()), 4);
    for (int i = 0; i < 4 && i < obs_data_q.size(); i++) check("single_literal", 32'(obs_data_q[i]), 32'(lit_data[i]));

    // burst, three passes of two samples
    d0 = done_cnt;
    build_exp(MODE_BURST, 1, 3, 0, n);
    start_play(MODE_BURST, 1, 3);
    ticks(n, 3);
    wait_idle(20);
    end_of_test("burst3", d0, 1);
    check("burst3_count", 32'(obs_addr_q.size()), 6);
    for (int i = 0; i < 6 && i < obs_addr_q.size(); i++) check("burst3_literal", 32'(obs_addr_q[i]), 32'(lit_burst[i]));

    // burst with rep_count 0 behaves as one pass
    d0 = done_cnt;
    build_exp(MODE_BURST, 1, 0, 0, n);
    start_play(MODE_BURST, 1, 0);
    ticks(n + 2, 3);
    wait_idle(20);
    end_of_test("burst0", d0, 1);
    check("burst0_count", 32'(obs_addr_q.size()), 2);

    // loop, write collision mid-play, then stop
    d0 = done_cnt;
    build_exp(MODE_LOOP, 2, 0, 7, n);
    start_play(MODE_LOOP, 2, 0);
    ticks(3, 4);
    wr_en = 1; wr_addr = 12'd3; wr_data = 16'd999;
    step();
    wr_en = 0;
    @(negedge clk);
    check("busy_write_we", 32'(bram_if.bram_we), 0);
    check("busy_write_err", 32'(wr_err), 1);
    step();
    ticks(4, 4);
    stop = 1; stop_cyc = cyc;
    step();
    stop = 0;
    @(negedge clk);
    check("stop_done_early", 32'(done), 0);
    check("stop_busy_early", 32'(busy), 1);
    step();
    @(negedge clk);
    check("stop_done", 32'(done), 1);
    check("stop_busy", 32'(busy), 0);
    step();
    end_of_test("loop", d0, 1);
    check("loop_count", 32'(obs_addr_q.size()), 7);
    for (int i = 0; i < 7 && i < obs_addr_q.size(); i++) check("loop_literal", 32'(obs_addr_q[i]), 32'(lit_loop[i]));

    // stop and tick in the same cycle: the tick is dropped
    d0 = done_cnt;
    build_exp(MODE_LOOP, 2, 0, 2, n);
    start_play(MODE_LOOP, 2, 0);
    ticks(2, 4);
    sample_tick = 1; stop = 1; stop_cyc = cyc;
    step();
    sample_tick = 0; stop = 0;
    wait_idle(10);
    end_of_test("stop_tick", d0, 1);

    // start and stop together in IDLE
    start = 1; stop = 1;
    step(); step();
    start = 0; stop = 0;
    @(negedge clk);
    check("start_stop_busy", 32'(busy), 0);
    check("start_stop_state", 32'(state_dbg), 32'(IDLE));
    step();

    // asynchronous reset mid-playback, then restart
    d0 = done_cnt;
    build_exp(MODE_LOOP, 3, 0, 2, n);
    start_play(MODE_LOOP, 3, 0);
    ticks(2, 4);
    sample_tick = 1;
    step();
    sample_tick = 0;
    #2 rst_n = 0;
    #1;
    check("async_rst_bram_en", 32'(bram_if.bram_en), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) step();
    rst_n = 1;
    repeat (2) step();
    end_of_test("reset", d0, 0);
    d0 = done_cnt;
    build_exp(MODE_SINGLE, 1, 0, 0, n);
    start_play(MODE_SINGLE, 1, 0);
    ticks(n, 2);
    wait_idle(20);
    end_of_test("restart", d0, 1);
    check("restart_first_addr", 32'(obs_addr_q.size() > 0 ? obs_addr_q[0] : 12'hfff), 0);

    // max_addr = 0 single: one read, valid and last together
    d0 = done_cnt;
    build_exp(MODE_SINGLE, 0, 0, 0, n);
    start_play(2'b11, 0, 0);
    ticks(3, 4);
    wait_idle(20);
    end_of_test("max0", d0, 1);
    check("max0_count", 32'(obs_addr_q.size()), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
